// File: rtl/condicionador_botoes_pkg.sv
// Shared constants for the LED-matrix puzzle: button count, clock rate,
// debounce time and move-counter width.
package jogo_pkg;

  localparam int N_BOTOES_DEF        = 8;
  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEBOUNCE_CICLOS_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int CONTADOR_W          = 8;

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: control inputs and raw buttons in, clean pulses,
// debounced levels and the move counter out.
interface condicionador_botoes_if
  import jogo_pkg::*;
#(
  parameter int N_BOTOES = N_BOTOES_DEF
);

  logic                  enable;
  logic                  limpa_contador;
  logic [N_BOTOES-1:0]   botoes_raw;
  logic [N_BOTOES-1:0]   botoes_pulso;
  logic [N_BOTOES-1:0]   botoes_estavel;
  logic                  jogada_feita;
  logic [CONTADOR_W-1:0] contador_jogadas;
  logic [N_BOTOES-1:0]   db_estavel;

  // Control unit / stimulus side
  modport master (
    output enable, limpa_contador, botoes_raw,
    input  botoes_pulso, botoes_estavel, jogada_feita, contador_jogadas, db_estavel
  );

  // Conditioner side
  modport slave (
    input  enable, limpa_contador, botoes_raw,
    output botoes_pulso, botoes_estavel, jogada_feita, contador_jogadas, db_estavel
  );

endinterface

// File: rtl/condicionador_botoes_debounce_bit.sv
// One button line: two-flop synchroniser followed by a counter that only
// accepts a new level after it has held for DEBOUNCE_CICLOS cycles.
module debounce_bit
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CICLOS)
) (
  input  logic clk,
  input  logic rst,
  input  logic botao_raw,
  output logic estavel
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             estavel_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Bring the asynchronous line into the clock domain
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= botao_raw;
      s2_reg <= s1_reg;
    end
  end

  // Accept a new level only after it differs from the stable one long enough
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg     <= '0;
      estavel_reg <= 1'b0;
    end else if (s2_reg == estavel_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      estavel_reg <= s2_reg;
      cnt_reg     <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign estavel = estavel_reg;

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: per-line debounce, rising-edge detect, lowest-index
// arbitration, enable gating and a saturating count of accepted moves.
module condicionador_botoes
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_DEF,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CICLOS)
) (
  input  logic                  clk,
  input  logic                  rst,
  condicionador_botoes_if.slave bus
);

  logic [N_BOTOES-1:0]   estavel;
  logic [N_BOTOES-1:0]   estavel_q_reg;
  logic [N_BOTOES-1:0]   rise;
  logic [N_BOTOES-1:0]   escolhido;
  logic [N_BOTOES-1:0]   pulso_reg;
  logic                  jogada_reg;
  logic [CONTADOR_W-1:0] contador_reg;

  generate
    for (genvar gi = 0; gi < N_BOTOES; gi++) begin : g_linha
      debounce_bit #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .botao_raw(bus.botoes_raw[gi]),
        .estavel  (estavel[gi])
      );
    end
  endgenerate

  // Rising edges only; x & -x isolates the lowest set bit, the rest are dropped
  assign rise      = estavel & ~estavel_q_reg;
  assign escolhido = rise & (~rise + N_BOTOES'(1));

  // Edge history, gated one-hot pulse and its OR, all registered together
  always_ff @(posedge clk) begin
    if (!rst) begin
      estavel_q_reg <= '0;
      pulso_reg     <= '0;
      jogada_reg    <= 1'b0;
    end else begin
      estavel_q_reg <= estavel;
      pulso_reg     <= bus.enable ? escolhido : '0;
      jogada_reg    <= bus.enable & (|escolhido);
    end
  end

  // Move counter: clear wins over increment, saturates at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      contador_reg <= '0;
    end else if (bus.limpa_contador) begin
      contador_reg <= '0;
    end else if ((|pulso_reg) && (contador_reg != {CONTADOR_W{1'b1}})) begin
      contador_reg <= contador_reg + CONTADOR_W'(1);
    end
  end

  assign bus.botoes_pulso     = pulso_reg;
  assign bus.botoes_estavel   = estavel;
  assign bus.db_estavel       = estavel;
  assign bus.jogada_feita     = jogada_reg;
  assign bus.contador_jogadas = contador_reg;

endmodule
